// File: rtl/clock_pkg.sv
// Shared definitions for the calendar sequencing controller.
// Latency: n/a (types, constants and a pure BCD helper).
// Backpressure: n/a.
package clock_pkg;

  // Controller states; the encoding doubles as the set_field value.
  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_SET_DAY   = 2'd1,
    ST_SET_MONTH = 2'd2,
    ST_SET_YEAR  = 2'd3
  } cal_state_e;

  // set_field encodings
  localparam logic [1:0] SF_NONE  = 2'd0;
  localparam logic [1:0] SF_DAY   = 2'd1;
  localparam logic [1:0] SF_MONTH = 2'd2;
  localparam logic [1:0] SF_YEAR  = 2'd3;

  // cnt_inc bit indices
  localparam int INC_DAY   = 0;
  localparam int INC_MONTH = 1;
  localparam int INC_YEAR  = 2;

  // cal_data nibble positions (LSB of each BCD digit)
  localparam int DAY_U_LSB = 28;
  localparam int DAY_T_LSB = 24;
  localparam int MON_U_LSB = 20;
  localparam int MON_T_LSB = 16;
  localparam int YR_U_LSB  = 12;
  localparam int YR_T_LSB  = 8;

  // Two BCD digits to binary; 8 bits so illegal digits cannot overflow.
  function automatic logic [7:0] bcd2bin(input logic [3:0] tens, input logic [3:0] units);
    return ({4'b0000, tens} * 8'd10) + {4'b0000, units};
  endfunction

endpackage

// File: rtl/cal_month_len.sv
// Decodes the calendar Data word into last-day-of-month, December and leap flags.
// Latency: purely combinational.
// Backpressure: none.
module cal_month_len
  import clock_pkg::*;
(
  input  logic [31:0] cal_data_i,
  output logic        is_last_day_o,
  output logic        is_dec_o,
  output logic        is_leap_o
);

  logic [7:0] day;
  logic [7:0] month;
  logic [7:0] year;
  logic [7:0] last_day;
  logic       cal_const_unused;

  // Low byte of Data is a constant and carries no date information.
  assign cal_const_unused = ^cal_data_i[7:0];

  // BCD to binary, leap rule (year 00 counts as leap) and month length
  always_comb begin
    day      = bcd2bin(cal_data_i[DAY_T_LSB +: 4], cal_data_i[DAY_U_LSB +: 4]);
    month    = bcd2bin(cal_data_i[MON_T_LSB +: 4], cal_data_i[MON_U_LSB +: 4]);
    year     = bcd2bin(cal_data_i[YR_T_LSB +: 4],  cal_data_i[YR_U_LSB +: 4]);
    is_leap_o = (year[1:0] == 2'b00);
    case (month)
      8'd1, 8'd3, 8'd5, 8'd7, 8'd8, 8'd10, 8'd12: last_day = 8'd31;
      8'd2:    last_day = is_leap_o ? 8'd29 : 8'd28;
      default: last_day = 8'd30;
    endcase
    is_last_day_o = (day == last_day);
    is_dec_o      = (month == 8'd12);
  end

endmodule

// File: rtl/calendar_ctrl.sv
// Chains midnight carries into day/month/year pulses and runs date-set mode.
// Latency: event sampled on edge N -> cnt_inc high N+1..N+2; next pulse no earlier than edge N+4.
// Backpressure: events inside the guard window (or ticks during set mode) are held one-deep.
// Optional feature macro: CAL_CTRL_BLINK_EN (builds the set-field blink counter).
module calendar_ctrl
  import clock_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 500_000_000,
  parameter int BLINK_HALF     = 25_000_000
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        day_tick,
  input  logic        key_mode,
  input  logic        key_inc,
  input  logic [31:0] cal_data,
  output logic [2:0]  cnt_inc,
  output logic [1:0]  set_field,
  output logic        blink
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  cal_state_e  state_q;
  logic [1:0]  set_field_q;
  logic [TW-1:0] to_q;
  logic        to_expire;

  logic [2:0]  cnt_inc_q, cnt_inc_d;
  logic [1:0]  guard_q, guard_d;
  logic        tick_pend_q, tick_pend_d;
  logic [2:0]  inc_pend_q, inc_pend_d;
  logic [2:0]  field_mask;
  logic        guard_clr, issue_tick, issue_inc;

  logic        is_last_day, is_dec;
  // Leap is already folded into is_last_day; the flag is exported for other users.
  logic        leap_unused;

  cal_month_len u_month_len (
    .cal_data_i    (cal_data),
    .is_last_day_o (is_last_day),
    .is_dec_o      (is_dec),
    .is_leap_o     (leap_unused)
  );

  // Idle timeout fires only when no key arrives in the same cycle
  assign to_expire = (state_q != ST_RUN) && !key_mode && !key_inc && (to_q == TO_LAST);

  // Mode FSM with registered field select and set-mode idle timeout
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q     <= ST_RUN;
      set_field_q <= SF_NONE;
      to_q        <= '0;
    end else if (key_mode) begin
      to_q <= '0;
      case (state_q)
        ST_RUN:       begin state_q <= ST_SET_DAY;   set_field_q <= SF_DAY;   end
        ST_SET_DAY:   begin state_q <= ST_SET_MONTH; set_field_q <= SF_MONTH; end
        ST_SET_MONTH: begin state_q <= ST_SET_YEAR;  set_field_q <= SF_YEAR;  end
        default:      begin state_q <= ST_RUN;       set_field_q <= SF_NONE;  end
      endcase
    end else if (state_q != ST_RUN) begin
      if (key_inc) begin
        to_q <= '0;
      end else if (to_expire) begin
        state_q     <= ST_RUN;
        set_field_q <= SF_NONE;
        to_q        <= '0;
      end else begin
        to_q <= to_q + TW'(1);
      end
    end
  end

  // Pulse arbitration: guard spacing, one-deep pendings, tick before inc
  always_comb begin
    field_mask = 3'b000;
    case (state_q)
      ST_SET_DAY:   field_mask[INC_DAY]   = 1'b1;
      ST_SET_MONTH: field_mask[INC_MONTH] = 1'b1;
      ST_SET_YEAR:  field_mask[INC_YEAR]  = 1'b1;
      default:      ;
    endcase

    guard_clr  = (guard_q == 2'd0);
    issue_tick = guard_clr && tick_pend_q && (state_q == ST_RUN);
    issue_inc  = guard_clr && !issue_tick && (inc_pend_q != 3'b000);

    cnt_inc_d = 3'b000;
    if (issue_tick) begin
      cnt_inc_d[INC_DAY]   = 1'b1;
      cnt_inc_d[INC_MONTH] = is_last_day;
      cnt_inc_d[INC_YEAR]  = is_last_day && is_dec;
    end else if (issue_inc) begin
      cnt_inc_d = inc_pend_q;
    end

    // Two blocked edges after a pulse: calendar counts, then Data settles.
    if (cnt_inc_d != 3'b000)  guard_d = 2'd2;
    else if (!guard_clr)      guard_d = guard_q - 2'd1;
    else                      guard_d = 2'd0;

    tick_pend_d = day_tick || (tick_pend_q && !issue_tick);

    if (key_inc && !key_mode && (state_q != ST_RUN)) inc_pend_d = field_mask;
    else if (issue_inc)                               inc_pend_d = 3'b000;
    else                                              inc_pend_d = inc_pend_q;
  end

  // Registered pulse output, guard counter and pendings
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      cnt_inc_q   <= 3'b000;
      guard_q     <= 2'd0;
      tick_pend_q <= 1'b0;
      inc_pend_q  <= 3'b000;
    end else begin
      cnt_inc_q   <= cnt_inc_d;
      guard_q     <= guard_d;
      tick_pend_q <= tick_pend_d;
      inc_pend_q  <= inc_pend_d;
    end
  end

  // Gate with reset so a pulse is never seen while reset is held.
  assign cnt_inc   = cnt_inc_q & {3{Reset_n}};
  assign set_field = set_field_q;

`ifdef CAL_CTRL_BLINK_EN
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  logic [BW-1:0] blink_cnt_q;
  logic          blink_q;

  // Blink half-period counter; restarts visible on state change or increment
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else if (key_mode || to_expire || (key_inc && (state_q != ST_RUN)) || (state_q == ST_RUN)) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_q <= '0;
      blink_q     <= ~blink_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + BW'(1);
    end
  end

  assign blink = blink_q;
`else
  localparam int blink_half_unused = BLINK_HALF;
  assign blink = 1'b0;
`endif

endmodule

// File: tb/tb_calendar_ctrl.sv
// Scoreboard bench for calendar_ctrl: drivers push expected pulses, a monitor pops them.
// Expected carries come from a plain date model (days-per-month table, leap by mod 4).
// Runs with TIMEOUT_CYCLES overridden to 20.
module tb_calendar_ctrl;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        day_tick;
  logic        key_mode;
  logic        key_inc;
  logic [31:0] cal_data;
  logic [2:0]  cnt_inc;
  logic [1:0]  set_field;
  logic        blink;

  typedef struct {
    int         cyc;
    logic [2:0] val;
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  calendar_ctrl #(
    .TIMEOUT_CYCLES (20),
    .BLINK_HALF     (4)
  ) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .day_tick  (day_tick),
    .key_mode  (key_mode),
    .key_inc   (key_inc),
    .cal_data  (cal_data),
    .cnt_inc   (cnt_inc),
    .set_field (set_field),
    .blink     (blink)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  // Monitor: every non-zero cnt_inc cycle must match the head of the scoreboard.
  always @(negedge Clk) begin
    exp_t e;
    if (cnt_inc !== 3'b000) begin
      checks++;
      if (sbq.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse cyc=%0d got=%b required=none", cyc, cnt_inc);
      end else begin
        e = sbq.pop_front();
        if (cnt_inc !== e.val || cyc != e.cyc) begin
          failures++;
          $display("FAIL pulse got=%b@cyc%0d required=%b@cyc%0d", cnt_inc, cyc, e.val, e.cyc);
        end
      end
    end else if (sbq.size() > 0 && sbq[0].cyc < cyc) begin
      checks++;
      failures++;
      e = sbq.pop_front();
      $display("FAIL missing_pulse cyc=%0d got=none required=%b@cyc%0d", cyc, e.val, e.cyc);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s got=%0h required=%0h", name, got, req);
    end
  endtask

  function automatic logic [31:0] mk(input int d, input int m, input int y);
    logic [31:0] w;
    w[31:28] = 4'(d % 10);
    w[27:24] = 4'(d / 10);
    w[23:20] = 4'(m % 10);
    w[19:16] = 4'(m / 10);
    w[15:12] = 4'(y % 10);
    w[11:8]  = 4'(y / 10);
    w[7:0]   = 8'hA5;
    return w;
  endfunction

  function automatic int days_in(input int m, input int y);
    int dim[12];
    dim = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    if (m == 2 && (y % 4) == 0) return 29;
    return dim[m-1];
  endfunction

  // Carry produced by one midnight on date d-m-y.
  function automatic logic [2:0] exp_carry(input int d, input int m, input int y);
    logic [2:0] r;
    r[0] = 1'b1;
    r[1] = (d == days_in(m, y));
    r[2] = r[1] && (m == 12);
    return r;
  endfunction

  task automatic expect_at(input int c, input logic [2:0] v);
    exp_t e;
    e.cyc = c;
    e.val = v;
    sbq.push_back(e);
  endtask

  // All driving happens 1 time unit after a rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) step(1);
  endtask

  task automatic tick_p();
    day_tick = 1'b1; step(1); day_tick = 1'b0;
  endtask

  task automatic mode_p();
    key_mode = 1'b1; step(1); key_mode = 1'b0;
  endtask

  task automatic inc_p();
    key_inc = 1'b1; step(1); key_inc = 1'b0;
  endtask

  task automatic d_tick(input int d, input int m, input int y, input logic [2:0] req);
    cal_data = mk(d, m, y);
    expect_at(cyc + 2, req);
    tick_p();
    step(4);
  endtask

  initial begin
    int k, m0, d, mo, y, both;
    logic [2:0] tick_exp;
    Reset_n  = 1'b0;
    day_tick = 1'b0;
    key_mode = 1'b0;
    key_inc  = 1'b0;
    cal_data = mk(1, 1, 25);
    step(3);
    chk("rst_cnt_inc", 32'(cnt_inc), 0);
    chk("rst_set_field", 32'(set_field), 0);
    chk("rst_blink", 32'(blink), 0);
    Reset_n = 1'b1;
    step(2);

    // Month and year carries, February cases
    d_tick(31, 1, 25, 3'b011);
    d_tick(31, 12, 99, 3'b111);
    d_tick(28, 2, 24, 3'b001);
    d_tick(28, 2, 25, 3'b011);
    d_tick(29, 2, 0, 3'b011);
    d_tick(30, 6, 10, 3'b011);
    d_tick(15, 7, 50, 3'b001);

    // Set mode; mode+inc together: mode wins, inc dropped
    cal_data = mk(15, 12, 30);
    mode_p();
    chk("set_day_field", 32'(set_field), 1);
    step(3);
    key_mode = 1'b1; key_inc = 1'b1; step(1); key_mode = 1'b0; key_inc = 1'b0;
    chk("set_month_field", 32'(set_field), 2);
    step(3);
    expect_at(cyc + 2, 3'b010);
    inc_p();
    step(4);
    chk("set_month_still", 32'(set_field), 2);
    mode_p();
    chk("set_year_field", 32'(set_field), 3);
    step(3);
    mode_p();
    chk("back_to_run", 32'(set_field), 0);
    chk("run_blink", 32'(blink), 0);
    step(4);

    // Tick held during set mode, released by timeout
    cal_data = mk(30, 4, 25);
    m0 = cyc;
    mode_p();
    chk("to_enter", 32'(set_field), 1);
    step(2);
    tick_p();
    expect_at(m0 + 22, 3'b011);
    wait_until(m0 + 20);
    chk("to_before", 32'(set_field), 1);
    step(1);
    chk("to_after", 32'(set_field), 0);
    step(6);

    // Back-to-back ticks: second pulse 3 cycles after the first
    cal_data = mk(10, 5, 25);
    k = cyc;
    expect_at(k + 2, 3'b001);
    expect_at(k + 5, 3'b001);
    day_tick = 1'b1; step(2); day_tick = 1'b0;
    step(6);

    // Reset inside the guard window drops the pending tick
    k = cyc;
    expect_at(k + 2, 3'b001);
    day_tick = 1'b1; step(2); day_tick = 1'b0;
    step(1);
    Reset_n = 1'b0;
    chk("rst_gate_cnt_inc", 32'(cnt_inc), 0);
    step(1);
    chk("rst_mid_cnt_inc", 32'(cnt_inc), 0);
    chk("rst_mid_set_field", 32'(set_field), 0);
    chk("rst_mid_blink", 32'(blink), 0);
    step(1);
    Reset_n = 1'b1;
    step(8);

    // Random midnight carries
    repeat (30) begin
      mo = $urandom_range(1, 12);
      y  = $urandom_range(0, 99);
      d  = ($urandom_range(0, 1) == 1) ? days_in(mo, y) : $urandom_range(1, days_in(mo, y));
      cal_data = mk(d, mo, y);
      expect_at(cyc + 2, exp_carry(d, mo, y));
      tick_p();
      step($urandom_range(3, 6));
    end

    // Random set-mode increments, optionally with a simultaneous tick
    repeat (8) begin
      k  = $urandom_range(1, 3);
      mo = $urandom_range(1, 12);
      y  = $urandom_range(0, 99);
      d  = ($urandom_range(0, 1) == 1) ? days_in(mo, y) : $urandom_range(1, days_in(mo, y));
      cal_data = mk(d, mo, y);
      tick_exp = exp_carry(d, mo, y);
      for (int i = 0; i < k; i++) begin
        mode_p();
        step(4);
      end
      chk("rnd_field", 32'(set_field), 32'(k));
      both = $urandom_range(0, 1);
      expect_at(cyc + 2, 3'(1 << (k - 1)));
      day_tick = (both == 1);
      key_inc  = 1'b1;
      step(1);
      day_tick = 1'b0;
      key_inc  = 1'b0;
      step(4);
      for (int i = k; i < 4; i++) begin
        if (i == 3 && both == 1) expect_at(cyc + 2, tick_exp);
        mode_p();
        step(4);
      end
      chk("rnd_run", 32'(set_field), 0);
    end

    step(6);
    chk("scoreboard_empty", 32'(sbq.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
